bias_stream_loader: RTL and testbench
=====================================

Name: bias_stream_loader

Overview:
- Write-side counterpart of the MLP bias store.
- Accepts a byte stream of per-layer bias records over a valid/ready handshake and writes signed 8-bit biases into an internal 128-entry bias RAM.
- Serves the datapath through the same registered read port: bias index = input_addr[15:9].
- Sits between the host/config interface and the neuron datapath, so biases become loadable at runtime instead of fixed at build time.

Parameters:
- NUM_LAYERS, 3, number of valid layer records (layer ids 0..NUM_LAYERS-1).
- LAYER_STRIDE, 32, RAM index base spacing per layer (layer L starts at L*32).
- MAX_PER_LAYER, 32, maximum biases accepted per layer record.
- IDX_W, 7, bias RAM index width (128 entries).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  stream byte (header, bias or checksum).
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- busy  out  1  a load is in progress (not IDLE).
- load_done  out  1  one-cycle pulse when the terminator header is consumed.
- load_err  out  1  sticky error flag; cleared by reset or by the next load start.
- input_addr  in  16  datapath address; bits [15:9] select the bias entry.
- bias_val  out  8  signed bias; registered read.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - s_ready=0, busy=0, load_done=0, load_err=0, bias_val=0, FSM=IDLE.
  - RAM contents are not cleared by reset; their power-up value is 0.
- Handshake:
  - A byte transfers when s_valid&&s_ready on a rising edge.
  - s_ready depends only on state, never combinationally on s_valid.
- Header byte format: [7:6] layer id, [5:0] count.
- FSM states:
  - IDLE:
    - s_ready=1.
    - The first accepted byte is a header: it clears load_err, sets busy and is processed as in HDR.
  - HDR, on an accepted header:
    - count==0: terminator. Pulse load_done next cycle, go to IDLE.
    - layer>=NUM_LAYERS: set load_err, go to DRAIN with remaining=count.
    - count>MAX_PER_LAYER: set load_err, write the first 32 bytes, drain the rest.
    - Otherwise go to DATA with idx=layer*LAYER_STRIDE and remaining=count.
  - DATA:
    - Each accepted byte writes RAM[idx]; idx increments and remaining decrements.
    - When remaining hits 0, go to CHK (feature on) or HDR.
    - idx never crosses into the next layer's window.
  - DRAIN: accept and discard remaining bytes, then go to HDR.
- busy is high in every state except IDLE. The cycle after a load_done pulse, busy=0.
- Read port:
  - bias_val <= RAM[input_addr[15:9]] each cycle (1-cycle latency); reset forces 0.
  - A write and a read to the same index in the same cycle returns the OLD value; the new value is visible the next cycle.
- Index 127 is addressable. Unwritten entries keep their prior value.
- Reset mid-load: the FSM returns to IDLE and partially written entries stay as written.
- s_valid deasserted mid-record: the FSM holds state indefinitely; there is no timeout.

Optional Feature:
- Macro: BIAS_LOADER_CHECKSUM_EN.
- Defined:
  - Each data record is followed by one checksum byte in state CHK.
  - The checksum is the mod-256 sum of the header byte and all data bytes, including drained bytes.
  - A mismatch sets load_err; the written biases are not rolled back.
  - The terminator header has no checksum.
- Undefined: there is no CHK state, and records are header plus data only.

Decomposition:
- Shared package mlp_pkg holds:
  - Constants: NUM_LAYERS, LAYER_STRIDE, MAX_PER_LAYER, BIAS_IDX_W=7.
  - Type bias_t (signed 8-bit).
  - The loader state enum.
  - Header field positions.
- One sub-module, bias_ram: 128x8 synchronous-write, registered-read RAM with a reset-to-0 output register.
- The FSM and counters live in bias_stream_loader.

Test Plan:
- Basic load (feature off):
  - Stimulus: stream 0x03,0x05,0xFE,0x7F,0x00 (layer0 count3, then terminator).
  - Response: load_done pulses once; input_addr=16'h0000 / 16'h0200 / 16'h0400 read 5 / -2 / 127, one cycle after the address is applied.
- Layer base:
  - Stimulus: 0x82 then 0x01,0x02.
  - Response: input_addr[15:9]=64 and 65 read 1 and 2; index 63 is unchanged.
- Bad layer:
  - Stimulus: header 0xC2, two data bytes, terminator.
  - Response: load_err=1, no RAM change, load_done pulses.
- Overlong record:
  - Stimulus: header 0x28 (layer0 count 40) with bytes 1..40.
  - Response: indices 0..31 hold 1..32, index 32 is untouched, load_err=1.
- Backpressure and reset:
  - Stimulus: toggle s_valid randomly mid-record, then assert reset after 2 of 4 data bytes.
  - Response: busy=0 and s_ready=0 during reset, s_ready=1 after; first 2 entries written; bias_val=0 during reset.
- Checksum (feature on):
  - Stimulus: 0x02,0x10,0x20, checksum 0x32.
  - Response: load_err=0.
  - Stimulus: repeat with checksum 0x33.
  - Response: load_err=1, data is still written.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared MLP constants, bias types and loader state encoding.
// BIAS_LOADER_CHECKSUM_EN adds a per-record checksum state.
package mlp_pkg;

  localparam int NUM_LAYERS    = 3;
  localparam int LAYER_STRIDE  = 32;
  localparam int MAX_PER_LAYER = 32;
  localparam int BIAS_IDX_W    = 7;
  localparam int BIAS_DEPTH    = 1 << BIAS_IDX_W;

  localparam int HDR_LAYER_MSB = 7;
  localparam int HDR_LAYER_LSB = 6;
  localparam int HDR_CNT_MSB   = 5;
  localparam int HDR_CNT_LSB   = 0;

  localparam int ADDR_IDX_MSB  = 15;
  localparam int ADDR_IDX_LSB  = 9;

  typedef logic signed [7:0] bias_t;
  typedef logic [1:0] layer_t;
  typedef logic [5:0] count_t;
  typedef logic [BIAS_IDX_W-1:0] bias_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN
`ifdef BIAS_LOADER_CHECKSUM_EN
    ,
    ST_CHK
`endif
  } ld_state_t;

  localparam count_t MAX_CNT = count_t'(MAX_PER_LAYER);

  function automatic bias_idx_t layer_base(
    input layer_t l
  );
    return bias_idx_t'(int'(l) * LAYER_STRIDE);
  endfunction

  function automatic logic layer_ok(
    input layer_t l
  );
    return int'(l) < NUM_LAYERS;
  endfunction

endpackage

// File: rtl/bias_ram.sv
// 128x8 bias RAM: synchronous write, registered read.
// Read returns the pre-write value on a same-index collision.
module bias_ram
  import mlp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [BIAS_IDX_W-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [BIAS_IDX_W-1:0] raddr,
  output logic [7:0]            rdata
);

  bias_t mem [BIAS_DEPTH];
  bias_t rdata_q;
  bias_t rdata_d;

  // storage array, never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read mux ahead of the output register
  always_comb begin
    rdata_d = mem[raddr];
  end

  // output register, forced to zero in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bias_stream_loader.sv
// Streams per-layer bias records into the bias RAM.
// Option: BIAS_LOADER_CHECKSUM_EN (checksum byte per record).
module bias_stream_loader
  import mlp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  input  logic [15:0] input_addr,
  output logic [7:0]  bias_val
);

`ifdef BIAS_LOADER_CHECKSUM_EN
  localparam ld_state_t REC_END = ST_CHK;
`else
  localparam ld_state_t REC_END = ST_HDR;
`endif

  ld_state_t state_q, state_d;
  bias_idx_t idx_q, idx_d;
  count_t    rem_q, rem_d;
  count_t    extra_q, extra_d;
  logic      err_q, err_d;
  logic      done_q, done_d;
  logic      rdy_q, rdy_d;
`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic      xfer;
  layer_t    hdr_layer;
  count_t    hdr_cnt;
  logic      ram_we;
  logic      unused_addr;

  assign xfer      = s_valid && rdy_q;
  assign hdr_layer = s_data[HDR_LAYER_MSB:HDR_LAYER_LSB];
  assign hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign unused_addr = ^input_addr[ADDR_IDX_LSB-1:0];

  // next-state, counters and write strobe
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    extra_d = extra_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rdy_d   = 1'b1;
    ram_we  = 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_HDR: begin
        if (xfer) begin
          if (state_q == ST_IDLE) begin
            err_d = 1'b0;
          end
`ifdef BIAS_LOADER_CHECKSUM_EN
          sum_d = s_data;
`endif
          if (hdr_cnt == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (!layer_ok(hdr_layer)) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
            rem_d   = hdr_cnt;
            extra_d = '0;
          end else begin
            state_d = ST_DATA;
            idx_d   = layer_base(hdr_layer);
            if (hdr_cnt > MAX_CNT) begin
              err_d   = 1'b1;
              rem_d   = MAX_CNT;
              extra_d = hdr_cnt - MAX_CNT;
            end else begin
              rem_d   = hdr_cnt;
              extra_d = '0;
            end
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          ram_we = 1'b1;
          idx_d  = idx_q + 7'd1;
          rem_d  = rem_q - 6'd1;
`ifdef BIAS_LOADER_CHECKSUM_EN
          sum_d  = sum_q + s_data;
`endif
          if (rem_q == 6'd1) begin
            if (extra_q != '0) begin
              state_d = ST_DRAIN;
              rem_d   = extra_q;
              extra_d = '0;
            end else begin
              state_d = REC_END;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          rem_d = rem_q - 6'd1;
`ifdef BIAS_LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data;
`endif
          if (rem_q == 6'd1) begin
            state_d = REC_END;
          end
        end
      end
`ifdef BIAS_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          if (s_data != sum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_HDR;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      extra_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      extra_q <= extra_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
`ifdef BIAS_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign s_ready   = rdy_q;
  assign busy      = (state_q != ST_IDLE);
  assign load_done = done_q;
  assign load_err  = err_q;

  bias_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (s_data),
    .raddr (input_addr[ADDR_IDX_MSB:ADDR_IDX_LSB]),
    .rdata (bias_val)
  );

endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed + randomized bench for bias_stream_loader.
// Reference model applies record rules to a 128-entry array.
module tb_bias_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [15:0] input_addr = '0;
  logic [7:0]  bias_val;

  bias_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .input_addr (input_addr),
    .bias_val   (bias_val)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_exp = 0;

  logic [7:0] model_mem [128];
  bit         known [128];
  bit         model_err = 1'b0;
  bit         in_load = 1'b0;
  logic [7:0] pay [$];

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("s_ready_wait", 32'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // header + pay[] (+ checksum); model applies the record rules
  task automatic send_record(
    input logic [7:0] hdr,
    input bit         bad_chk
  );
    int layer;
    int cnt;
    logic [7:0] sum;
    layer = int'(hdr[7:6]);
    cnt   = int'(hdr[5:0]);
    if (!in_load) begin
      model_err = 1'b0;
      in_load   = 1'b1;
    end
    sum = hdr;
    send_byte(hdr);
    for (int i = 0; i < cnt; i++) begin
      send_byte(pay[i]);
      sum = sum + pay[i];
      if (layer < 3 && i < 32) begin
        model_mem[layer * 32 + i] = pay[i];
        known[layer * 32 + i] = 1'b1;
      end
    end
    if (layer >= 3 || cnt > 32) model_err = 1'b1;
`ifdef BIAS_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? sum + 8'd1 : sum);
    if (bad_chk) model_err = 1'b1;
`else
    if (bad_chk) sum = '0;
`endif
  endtask

  task automatic send_term();
    logic [1:0] l;
    l = 2'($urandom);
    send_byte({l, 6'd0});
    done_exp++;
    in_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("load_done", done_cnt, done_exp);
    check("busy_idle", 32'(busy), 0);
    check("load_err", 32'(load_err), 32'(model_err));
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic check_read(input int idx);
    @(negedge clk);
    input_addr = {7'(idx), 9'($urandom)};
    @(negedge clk);
    if (known[idx]) begin
      check($sformatf("rd%0d", idx),
            32'(bias_val), 32'(model_mem[idx]));
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 96; i++) check_read(i);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      model_mem[i] = '0;
      known[i] = 1'b0;
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_err", 32'(load_err), 0);
    check("rst_bias", 32'(bias_val), 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 1);
    check("busy_after_rst", 32'(busy), 0);

    // fill all three layer windows with known data
    fill_rand(32); send_record(8'h20, 1'b0);
    fill_rand(32); send_record(8'h60, 1'b0);
    fill_rand(32); send_record(8'hA0, 1'b0);
    send_term();
    sweep();

    // basic load: 5, -2, 127 at indices 0..2
    pay = '{8'h05, 8'hFE, 8'h7F};
    send_record(8'h03, 1'b0);
    send_term();
    for (int i = 0; i < 4; i++) check_read(i);

    // layer base: layer 2 count 2
    pay = '{8'h01, 8'h02};
    send_record(8'h82, 1'b0);
    @(negedge clk);
    check("busy_mid_load", 32'(busy), 1);
    send_term();
    for (int i = 62; i < 67; i++) check_read(i);

    // bad layer: nothing written, error flagged
    pay = '{8'hAA, 8'hBB};
    send_record(8'hC2, 1'b0);
    send_term();
    sweep();

    // overlong record: 40 bytes, first 32 kept
    pay.delete();
    for (int i = 1; i <= 40; i++) pay.push_back(8'(i));
    send_record(8'h28, 1'b0);
    send_term();
    for (int i = 0; i < 34; i++) check_read(i);

    // clean load clears the sticky error
    fill_rand(5);
    send_record(8'h45, 1'b0);
    send_term();

`ifdef BIAS_LOADER_CHECKSUM_EN
    pay = '{8'h10, 8'h20};
    send_record(8'h02, 1'b0);
    send_term();
    pay = '{8'h10, 8'h20};
    send_record(8'h02, 1'b1);
    send_term();
    check_read(0);
    check_read(1);
`endif

    // randomized multi-record loads
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 3; r++) begin
        logic [7:0] h;
        h = {2'($urandom_range(0, 3)),
             6'($urandom_range(1, 63))};
        fill_rand(int'(h[5:0]));
        send_record(h, ($urandom % 4) == 0);
      end
      send_term();
      sweep();
    end

    // reset after 2 of 4 data bytes
    send_byte(8'h04);
    send_byte(8'h5A);
    send_byte(8'hA5);
    model_mem[0] = 8'h5A;
    model_mem[1] = 8'hA5;
    known[0] = 1'b1;
    known[1] = 1'b1;
    @(negedge clk);
    check("busy_pre_rst", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(s_ready), 0);
    check("mid_rst_bias", 32'(bias_val), 0);
    check("mid_rst_err", 32'(load_err), 0);
    reset = 1'b0;
    in_load = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) check_read(i);

    // recovery load after reset
    fill_rand(7);
    send_record(8'h07, 1'b0);
    send_term();
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
